// File: rtl/iq_interp_fir.sv
// rtl/iq_interp_fir.sv - I/Q interpolation FIR with shared programmable taps, fixed 3-cycle latency
module iq_interp_fir #(
    parameter int IN_W   = 4,
    parameter int COEF_W = 8,
    parameter int NTAPS  = 16,
    parameter int OUT_W  = IN_W + COEF_W + $clog2(NTAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [IN_W-1:0]   iup,
    input  logic signed [IN_W-1:0]   qup,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [OUT_W-1:0]  ifilt,
    output logic signed [OUT_W-1:0]  qfilt,
    output logic                     out_valid
);

    localparam int PW = IN_W + COEF_W;

    logic signed [IN_W-1:0]   tap_i_q  [NTAPS];
    logic signed [IN_W-1:0]   tap_q_q  [NTAPS];
    logic signed [COEF_W-1:0] coef_q   [NTAPS];
    logic signed [PW-1:0]     p_i_q    [NTAPS];
    logic signed [PW-1:0]     p_q_q    [NTAPS];
    logic signed [PW-1:0]     p_i_d    [NTAPS];
    logic signed [PW-1:0]     p_q_d    [NTAPS];
    logic signed [OUT_W-1:0]  sum_i_q, sum_q_q;
    logic signed [OUT_W-1:0]  sum_i_d, sum_q_d;
    logic [2:0]               v_q;

    // Delay lines advance only on accepted samples; coefficient writes are independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                tap_i_q[k] <= '0;
                tap_q_q[k] <= '0;
                coef_q[k]  <= '0;
            end
        end else begin
            if (en) begin
                tap_i_q[0] <= iup;
                tap_q_q[0] <= qup;
                for (int k = 1; k < NTAPS; k++) begin
                    tap_i_q[k] <= tap_i_q[k-1];
                    tap_q_q[k] <= tap_q_q[k-1];
                end
            end
            if (coef_we) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    // Operands are sign-extended to the product width so the multiply stays fully signed.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            p_i_d[k] = $signed({{COEF_W{tap_i_q[k][IN_W-1]}}, tap_i_q[k]})
                     * $signed({{IN_W{coef_q[k][COEF_W-1]}}, coef_q[k]});
            p_q_d[k] = $signed({{COEF_W{tap_q_q[k][IN_W-1]}}, tap_q_q[k]})
                     * $signed({{IN_W{coef_q[k][COEF_W-1]}}, coef_q[k]});
        end
    end

    always_comb begin
        sum_i_d = '0;
        sum_q_d = '0;
        for (int k = 0; k < NTAPS; k++) begin
            sum_i_d = sum_i_d + $signed({{(OUT_W-PW){p_i_q[k][PW-1]}}, p_i_q[k]});
            sum_q_d = sum_q_d + $signed({{(OUT_W-PW){p_q_q[k][PW-1]}}, p_q_q[k]});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                p_i_q[k] <= '0;
                p_q_q[k] <= '0;
            end
            sum_i_q <= '0;
            sum_q_q <= '0;
            v_q     <= '0;
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                p_i_q[k] <= p_i_d[k];
                p_q_q[k] <= p_q_d[k];
            end
            sum_i_q <= sum_i_d;
            sum_q_q <= sum_q_d;
            v_q     <= {v_q[1:0], en};
        end
    end

    assign ifilt     = sum_i_q;
    assign qfilt     = sum_q_q;
    assign out_valid = v_q[2];

endmodule
